d_mem_controller: RTL and testbench
===================================

# d_mem_controller

Data-memory controller directly downstream of the load/store queue. It accepts one memory request at a time over the LSQ's request handshake, holds it for a fixed, parameterised access latency, and performs the access on an internal word array. For a read it returns the data with a one-cycle done pulse; a write completes with the same pulse. It is the sole owner of data-memory state in the core.

## Interface
- `MEM_LATENCY`, 2: cycles from request acceptance to the done pulse; legal values are ≥1.
- `MEM_DEPTH`, 1024: number of `REG_VAL_WIDTH`-bit words; must be a power of two.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `lsq_req_valid`  in  1  request strobe.
- `lsq_req_op`  in  memory_op_t  `mem_read`, `mem_write` or `no_mem_op`.
- `lsq_req_address`  in  `D_MEMORY_ADDR_WIDTH`  byte address.
- `lsq_req_data`  in  `REG_VAL_WIDTH`  store data.
- `mem_ctrl_ready`  out  1  controller can accept a request.
- `mem_ctrl_done`  out  1  single-cycle completion pulse.
- `mem_ctrl_data`  out  `REG_VAL_WIDTH`  load result, valid only while done is high.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- `mem_ctrl_ready` = (state == IDLE). It is combinational.
- **Acceptance:** a request is accepted in an IDLE cycle where `lsq_req_valid`=1 and `lsq_req_op` != `no_mem_op`.
  - The op, word index, and data are latched.
  - If `MEM_LATENCY`==1, next state is RESP.
  - Otherwise next state is WAIT, and the counter loads `MEM_LATENCY`-2.
- **Ignored requests:**
  - Valid with `no_mem_op` is ignored; the FSM stays in IDLE and no done pulse is produced.
  - Valid outside IDLE is ignored; the latched request is unchanged.
- **WAIT:** if counter==0, go to RESP; otherwise decrement. Counter width is `$clog2(MEM_LATENCY+1)`, and it never wraps.
- **Entering RESP:**
  - For a read, `array[index]` is captured into the read-data register.
  - For a write, the read-data register is loaded with 0.
- **RESP:** `mem_ctrl_done`=1 for exactly one cycle, then the FSM returns to IDLE.
  - A write updates `array[index]` on the edge ending RESP.
- **Word index:** `lsq_req_address[$clog2(MEM_DEPTH)+1:2]`.
  - Bits [1:0] are ignored; there is no misalignment fault.
  - Upper bits are ignored, so addresses alias modulo `MEM_DEPTH`*4.
- `mem_ctrl_data` is driven from the read-data register while done=1 and is 0 otherwise.
- **Array initialisation:** the array is not reset, so contents are undefined until written.
- **Read-after-write:** a write commits before the next request can be accepted, so a following read to the same address always returns the new value.

## Timing
- Acceptance happens at the edge ending cycle t. Done is high in cycle t+`MEM_LATENCY`.
- Ready is 0 from t+1 through t+`MEM_LATENCY` and returns to 1 in cycle t+`MEM_LATENCY`+1.
- The earliest next acceptance is cycle t+`MEM_LATENCY`+1, giving a throughput of one request per `MEM_LATENCY`+1 cycles.
- **While reset is asserted:**
  - State = IDLE, counter = 0, latched request = 0, read-data register = 0.
  - `mem_ctrl_ready`=1, `mem_ctrl_done`=0, `mem_ctrl_data`=0.
- **Reset asserted mid-operation (WAIT or RESP):**
  - The FSM returns to IDLE immediately and done drops asynchronously.
  - A pending write is discarded: if reset asserts during RESP, the array is not written.
  - Array contents already committed are retained.
- **Relation to the LSQ:**
  - The LSQ presents a one-cycle valid pulse only while ready=1, so acceptance always takes exactly that cycle.
  - The LSQ registers done for loads. Done must therefore never be asserted for two consecutive cycles.

## Structure
- Shared package/defines hold `memory_op_t` (`no_mem_op`, `mem_read`, `mem_write`), `D_MEMORY_ADDR_WIDTH` and `REG_VAL_WIDTH`. These are reused, not redeclared.
- The FSM state enum is local to the module.
- One sub-module, `d_mem_array`:
  - `MEM_DEPTH` × `REG_VAL_WIDTH` storage.
  - Synchronous write with write enable, asynchronous read, and no reset.
  - The controller instantiates it once.

## Test plan
- **Write then read (`MEM_LATENCY`=2):**
  - Write 0xDEADBEEF to 0x40, accepted at t, gives done at t+2 with data 0 and ready at t+3.
  - Read 0x40 accepted at t+3 gives done at t+5 with data 0xDEADBEEF.
- **No-op and busy requests:** valid with `no_mem_op` in IDLE leaves ready=1 and produces no done. Valid with a read of 0x80 during WAIT is ignored; only the original request's done appears.
- **Back-to-back (`MEM_LATENCY`=1):**
  - Write 5 to 0x10, accepted at t, gives done at t+1.
  - A read of 0x10 accepted at t+2 gives done at t+3 with data 5.
- **Aliasing (`MEM_DEPTH`=1024):**
  - Write 0x1234 to 0x1000 and read 0x0000; the read returns 0x1234.
  - Read 0x0003; it returns 0x1234 (low bits ignored).
- **Reset during RESP:**
  - First write 7 to 0x20. Then start a write of 9 to 0x20 and assert reset in its RESP cycle.
  - Done drops immediately and ready=1 while reset is held.
  - After release, a read of 0x20 returns 7.
- **Reset values:** while reset=0, ready=1, done=0 and data=0, regardless of `lsq_req_valid` activity.

Source files
------------

// File: rtl/d_mem_controller_pkg.sv
// Types and widths shared by the load/store path and the data-memory controller.
package d_mem_controller_pkg;

   localparam int D_MEMORY_ADDR_WIDTH = 32;
   localparam int REG_VAL_WIDTH       = 32;

   typedef enum logic [1:0] {
      no_mem_op = 2'd0,
      mem_read  = 2'd1,
      mem_write = 2'd2
   } memory_op_t;

endpackage

// File: rtl/d_mem_controller_array.sv
// Word storage for the data memory: synchronous write, asynchronous read.
module d_mem_array #(
   parameter int MEM_DEPTH = 1024,
   parameter int WIDTH     = 32
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] wr_idx,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic [$clog2(MEM_DEPTH)-1:0] rd_idx,
   output logic [WIDTH-1:0]             rd_data
);

   logic [WIDTH-1:0] mem_q [MEM_DEPTH];

   // NOTE: the storage deliberately has no reset; a reset loop over every word would stop it
   // mapping onto RAM, and contents must survive a controller reset anyway.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/d_mem_controller.sv
// Single-outstanding data-memory controller: accepts one LSQ request, waits MEM_LATENCY cycles,
// then pulses done for one cycle (with load data for reads).
module d_mem_controller
   import d_mem_controller_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int MEM_DEPTH   = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           lsq_req_valid,
   input  memory_op_t                     lsq_req_op,
   input  logic [D_MEMORY_ADDR_WIDTH-1:0] lsq_req_address,
   input  logic [REG_VAL_WIDTH-1:0]       lsq_req_data,
   output logic                           mem_ctrl_ready,
   output logic                           mem_ctrl_done,
   output logic [REG_VAL_WIDTH-1:0]       mem_ctrl_data
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
   localparam logic [D_MEMORY_ADDR_WIDTH-1:0] ADDR_IDX_MASK =
      D_MEMORY_ADDR_WIDTH'(MEM_DEPTH - 1) << 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   memory_op_t               op_q, op_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [REG_VAL_WIDTH-1:0] wdata_q, wdata_d;
   logic [REG_VAL_WIDTH-1:0] rdata_q, rdata_d;

   logic [IDX_W-1:0]         req_idx;
   logic [IDX_W-1:0]         arr_rd_idx;
   logic [REG_VAL_WIDTH-1:0] arr_rd_data;
   logic                     arr_wr_en;
   logic                     addr_unused;

   // Byte address -> word index; low two bits and bits above the array size alias away.
   assign req_idx     = lsq_req_address[IDX_W+1:2];
   assign addr_unused = ^(lsq_req_address & ~ADDR_IDX_MASK);

   // With MEM_LATENCY==1 the read happens on the accepting edge, before idx_q holds the index.
   assign arr_rd_idx = (state_q == S_IDLE) ? req_idx : idx_q;
   assign arr_wr_en  = (state_q == S_RESP) && (op_q == mem_write);

   d_mem_array #(
      .MEM_DEPTH (MEM_DEPTH),
      .WIDTH     (REG_VAL_WIDTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_wr_en),
      .wr_idx  (idx_q),
      .wr_data (wdata_q),
      .rd_idx  (arr_rd_idx),
      .rd_data (arr_rd_data)
   );

   // NOTE: every _d gets its hold value first, so no path through the case leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (lsq_req_valid && (lsq_req_op != no_mem_op)) begin
               op_d    = lsq_req_op;
               idx_d   = req_idx;
               wdata_d = lsq_req_data;
               if (MEM_LATENCY == 1) begin
                  state_d = S_RESP;
                  rdata_d = (lsq_req_op == mem_read) ? arr_rd_data : '0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               rdata_d = (op_q == mem_read) ? arr_rd_data : '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= no_mem_op;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign mem_ctrl_ready = (state_q == S_IDLE);
   assign mem_ctrl_done  = (state_q == S_RESP);
   assign mem_ctrl_data  = mem_ctrl_done ? rdata_q : '0;

endmodule

// File: tb/tb_d_mem_controller.sv
// Directed bench for d_mem_controller at MEM_LATENCY=2 and MEM_LATENCY=1.
module tb_d_mem_controller;
   import d_mem_controller_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic        sel;
   memory_op_t  op;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        valid1, valid2;
   logic        ready1, ready2, done1, done2;
   logic [31:0] data1, data2;
   logic        rdy, dn;
   logic [31:0] dat;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // sel=0 drives the MEM_LATENCY=2 instance, sel=1 the MEM_LATENCY=1 instance.
   assign valid2 = valid & ~sel;
   assign valid1 = valid & sel;
   assign rdy    = sel ? ready1 : ready2;
   assign dn     = sel ? done1  : done2;
   assign dat    = sel ? data1  : data2;

   d_mem_controller #(.MEM_LATENCY(2), .MEM_DEPTH(1024)) dut2 (
      .clk             (clk),
      .reset           (reset),
      .lsq_req_valid   (valid2),
      .lsq_req_op      (op),
      .lsq_req_address (addr),
      .lsq_req_data    (wdata),
      .mem_ctrl_ready  (ready2),
      .mem_ctrl_done   (done2),
      .mem_ctrl_data   (data2)
   );

   d_mem_controller #(.MEM_LATENCY(1), .MEM_DEPTH(1024)) dut1 (
      .clk             (clk),
      .reset           (reset),
      .lsq_req_valid   (valid1),
      .lsq_req_op      (op),
      .lsq_req_address (addr),
      .lsq_req_data    (wdata),
      .mem_ctrl_ready  (ready1),
      .mem_ctrl_done   (done1),
      .mem_ctrl_data   (data1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One request: accepted at the edge after the first negedge, done expected LAT cycles later.
   task automatic do_req(input string tag, input memory_op_t o, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
      int lat;
      lat = sel ? 1 : 2;
      @(negedge clk);
      check($sformatf("%s ready_idle", tag), rdy, 1);
      check($sformatf("%s done_idle", tag), dn, 0);
      valid = 1'b1; op = o; addr = a; wdata = d;
      @(posedge clk);
      #1 valid = 1'b0; op = no_mem_op;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         check($sformatf("%s done_c%0d", tag, k), dn, (k == lat) ? 1 : 0);
         check($sformatf("%s ready_c%0d", tag, k), rdy, 0);
         check($sformatf("%s data_c%0d", tag, k), dat, (k == lat) ? exp : 32'h0);
      end
   endtask

   typedef struct {
      memory_op_t  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{mem_write, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
      vecs[1] = '{mem_read,  32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
      vecs[2] = '{mem_write, 32'h0000_1000, 32'h0000_1234, 32'h0};
      vecs[3] = '{mem_read,  32'h0000_0000, 32'h0,         32'h0000_1234};
      vecs[4] = '{mem_read,  32'h0000_0003, 32'h0,         32'h0000_1234};
      vecs[5] = '{mem_write, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0};
      vecs[6] = '{mem_read,  32'h0000_1FFC, 32'h0,         32'hA5A5_A5A5};
      vecs[7] = '{mem_write, 32'h0000_0080, 32'h8080_8080, 32'h0};
      vecs[8] = '{mem_write, 32'h0000_0044, 32'h0000_0055, 32'h0};
      vecs[9] = '{mem_read,  32'h0000_0040, 32'h0,         32'hDEAD_BEEF};

      reset = 1'b0; valid = 1'b0; sel = 1'b0; op = no_mem_op; addr = '0; wdata = '0;

      // Reset values hold regardless of request activity.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         valid = i[0]; op = mem_read; addr = 32'h40;
         check("rst ready2", ready2, 1);
         check("rst done2", done2, 0);
         check("rst data2", data2, 0);
         check("rst ready1", ready1, 1);
         check("rst done1", done1, 0);
         check("rst data1", data1, 0);
      end
      @(negedge clk);
      valid = 1'b0; op = no_mem_op;
      reset = 1'b1;

      // Table-driven requests on the latency-2 instance.
      sel = 1'b0;
      for (int i = 0; i < 10; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp);
      end

      // Valid with no_mem_op in IDLE is ignored.
      @(negedge clk);
      valid = 1'b1; op = no_mem_op; addr = 32'h40;
      @(posedge clk);
      #1 valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("noop ready", rdy, 1);
         check("noop done", dn, 0);
      end

      // A read of 0x80 offered during WAIT is ignored.
      @(negedge clk);
      check("busy ready_idle", rdy, 1);
      valid = 1'b1; op = mem_read; addr = 32'h40;
      @(posedge clk);
      #1 valid = 1'b0; op = no_mem_op;
      @(negedge clk);
      check("busy wait_done", dn, 0);
      check("busy wait_ready", rdy, 0);
      valid = 1'b1; op = mem_read; addr = 32'h80;
      @(posedge clk);
      #1 valid = 1'b0; op = no_mem_op;
      @(negedge clk);
      check("busy done", dn, 1);
      check("busy data", dat, 32'hDEAD_BEEF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("busy no_extra_done", dn, 0);
         check("busy ready_after", rdy, 1);
      end

      // Back-to-back on the latency-1 instance: accept at t, done t+1, next accept t+2.
      sel = 1'b1;
      do_req("lat1 wr", mem_write, 32'h10, 32'h5, 32'h0);
      do_req("lat1 rd", mem_read, 32'h10, 32'h0, 32'h5);
      do_req("lat1 rd_alias", mem_read, 32'h1012, 32'h0, 32'h5);

      // Reset during the RESP cycle of a write discards it.
      sel = 1'b0;
      do_req("rr wr7", mem_write, 32'h20, 32'h7, 32'h0);
      @(negedge clk);
      valid = 1'b1; op = mem_write; addr = 32'h20; wdata = 32'h9;
      @(posedge clk);
      #1 valid = 1'b0; op = no_mem_op;
      @(negedge clk);
      check("rr wait_done", dn, 0);
      @(negedge clk);
      check("rr resp_done", dn, 1);
      reset = 1'b0;
      #1;
      check("rr async_done", dn, 0);
      check("rr async_ready", rdy, 1);
      check("rr async_data", dat, 0);
      valid = 1'b1; op = mem_write; wdata = 32'hBAD;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rr held_ready", rdy, 1);
         check("rr held_done", dn, 0);
         check("rr held_data", dat, 0);
      end
      valid = 1'b0; op = no_mem_op;
      reset = 1'b1;
      do_req("rr rd", mem_read, 32'h20, 32'h0, 32'h7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
